// File: rtl/pa_rf_pkg.sv
// Shared constants for the multi-port PA-RISC general register file.
// Default widths, the hardwired-zero register index and write-back port indices.
package pa_rf_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NRD    = 2;

   localparam int ZERO_REG   = 0;

   // Write-back port indices; a higher index wins an address collision.
   localparam int NUM_WB     = 2;
   localparam int WB_ALU     = 0;
   localparam int WB_LOAD    = 1;

endpackage

// File: rtl/pa_regfile_mp_if.sv
// Decode/write-back bus of the multi-port register file.
// The master side (pipeline) drives addresses, writes and reserves; the slave (register file) returns data and busy bits.
interface pa_regfile_mp_if
   import pa_rf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NRD    = DEF_NRD
) ();

   logic [NRD*ADDR_W-1:0] RA;
   logic [NRD*DATA_W-1:0] PA;
   logic [NRD-1:0]        BUSY;

   logic                  EN0;
   logic [ADDR_W-1:0]     RD0;
   logic [DATA_W-1:0]     PD0;

   logic                  EN1;
   logic [ADDR_W-1:0]     RD1;
   logic [DATA_W-1:0]     PD1;

   logic                  RES_EN;
   logic [ADDR_W-1:0]     RES_ADDR;

   modport master (
      output RA, EN0, RD0, PD0, EN1, RD1, PD1, RES_EN, RES_ADDR,
      input  PA, BUSY
   );

   modport slave (
      input  RA, EN0, RD0, PD0, EN1, RD1, PD1, RES_EN, RES_ADDR,
      output PA, BUSY
   );

endinterface

// File: rtl/pa_rf_read_port.sv
// One combinational read port: array mux, optional write-through and busy release.
// Write-through is compiled in only when REGFILE_BYPASS_EN is defined.
module pa_rf_read_port
   import pa_rf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic [ADDR_W-1:0]                   ra,
   input  logic [DATA_W-1:0]                   regs [2**ADDR_W],
   input  logic [2**ADDR_W-1:0]                busy_bits,
   input  logic [NUM_WB-1:0]                   byp_en,
   input  logic [NUM_WB-1:0][ADDR_W-1:0]       byp_addr,
   input  logic [NUM_WB-1:0][DATA_W-1:0]       byp_data,
   input  logic                                res_en,
   input  logic [ADDR_W-1:0]                   res_addr,
   output logic [DATA_W-1:0]                   pa,
   output logic                                busy
);

   logic live;
   assign live = (ra != ADDR_W'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
   logic hit;

   always_comb begin
      // NOTE: every output gets a default first so no path through the block leaves a latch.
      pa   = '0;
      busy = 1'b0;
      hit  = 1'b0;
      if (live) begin
         pa   = regs[ra];
         busy = busy_bits[ra];
         // Ascending scan: the load port overrides the ALU port on a collision.
         for (int k = 0; k < NUM_WB; k++) begin
            if (byp_en[k] && (byp_addr[k] == ra)) begin
               pa  = byp_data[k];
               hit = 1'b1;
            end
         end
         // A same-cycle reserve supersedes the release of the old producer.
         if (hit && !(res_en && (res_addr == ra)))
            busy = 1'b0;
      end
   end
`else
   always_comb begin
      pa   = '0;
      busy = 1'b0;
      if (live) begin
         pa   = regs[ra];
         busy = busy_bits[ra];
      end
   end

   logic unused_bypass;
   assign unused_bypass = ^{byp_en, byp_addr, byp_data, res_en, res_addr};
`endif

endmodule

// File: rtl/pa_regfile_mp.sv
// Multi-port general register file: NRD read ports, ALU and load write-back, busy scoreboard, GR0 = 0.
// Define REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module pa_regfile_mp
   import pa_rf_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NRD    = DEF_NRD
) (
   input  logic          CLK,
   input  logic          RST,
   pa_regfile_mp_if.slave bus
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0]               regs [DEPTH];
   logic [DEPTH-1:0]                busy;

   logic [NUM_WB-1:0]               wr_en;
   logic [NUM_WB-1:0][ADDR_W-1:0]   wr_addr;
   logic [NUM_WB-1:0][DATA_W-1:0]   wr_data;
   logic [NUM_WB-1:0]               byp_en;
   logic                            res_live;

   // Writes and reserves to GR0 are dropped here so GR0 is never disturbed.
   assign wr_en[WB_ALU]    = bus.EN0 && (bus.RD0 != ADDR_W'(ZERO_REG));
   assign wr_addr[WB_ALU]  = bus.RD0;
   assign wr_data[WB_ALU]  = bus.PD0;
   assign wr_en[WB_LOAD]   = bus.EN1 && (bus.RD1 != ADDR_W'(ZERO_REG));
   assign wr_addr[WB_LOAD] = bus.RD1;
   assign wr_data[WB_LOAD] = bus.PD1;

   assign res_live = bus.RES_EN && (bus.RES_ADDR != ADDR_W'(ZERO_REG));
   assign byp_en   = wr_en & {NUM_WB{~RST}};

   always_ff @(posedge CLK) begin
      if (RST) begin
         // NOTE: the storage array is reset too, because every register must read 0 after reset.
         for (int r = 0; r < DEPTH; r++)
            regs[r] <= '0;
         busy <= '0;
      end else begin
         // NOTE: non-blocking updates to the same element resolve last-wins, giving load-port and reserve priority.
         for (int k = 0; k < NUM_WB; k++) begin
            if (wr_en[k]) begin
               regs[wr_addr[k]] <= wr_data[k];
               busy[wr_addr[k]] <= 1'b0;
            end
         end
         if (res_live)
            busy[bus.RES_ADDR] <= 1'b1;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      pa_rf_read_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_rd (
         .ra        (bus.RA[i*ADDR_W +: ADDR_W]),
         .regs      (regs),
         .busy_bits (busy),
         .byp_en    (byp_en),
         .byp_addr  (wr_addr),
         .byp_data  (wr_data),
         .res_en    (res_live),
         .res_addr  (bus.RES_ADDR),
         .pa        (bus.PA[i*DATA_W +: DATA_W]),
         .busy      (bus.BUSY[i])
      );
   end

endmodule
